keypad_entry: RTL
=================

Name: keypad_entry

Overview:
Scans a 4x4 matrix keypad, debounces it and reports each press once. It also maintains an 8-digit, high-digit-first entry buffer in the same 32-bit format the 7-segment scanner consumes, so the buffer can be wired straight to the display. Nibble value 4'hF means blank digit, which the display renders dark.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven; must be >= 4.
DEBOUNCE, 4, consecutive identical full sweeps required to accept a press or a release; must be >= 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
row  input  4  keypad rows, active-low (pulled up externally), asynchronous
col  output 4  keypad column drive, active-low, exactly one bit low at any time
data  output 32  entry buffer, 8 x 4-bit digits; data[31:28] is the leftmost digit
key_valid  output 1  one-cycle pulse per accepted press
key_code  output 4  code of the last accepted key, held until the next press
digit_cnt  output 4  number of entered digits, 0..8

Behaviour:
- Reset state, registered on clk edge with rst=1:
  - col=4'b1110, data=32'hFFFF_FFFF, key_valid=0, key_code=0, digit_cnt=0.
  - Scan divider, column index, debounce counter and press state are all cleared.
  - Row synchroniser flops are set to 4'hF.
- row passes through a 2-flop synchroniser; only the synchronised value is used.
- Column scan:
  - Column index c steps 0,1,2,3,0,... every SCAN_DIV cycles; col = ~(1<<c).
  - Rows are sampled on the last cycle of each column period.
  - One sweep = 4*SCAN_DIV cycles, ending on the column-3 sample.
- Key map, (row r, col c) -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Sweep classification:
  - NONE: no row low in any column.
  - SINGLE(k): exactly one (r,c) low.
  - MULTI: two or more (r,c) low.
- Debounce FSM, states IDLE and HELD:
  - IDLE:
    - SINGLE(k) equal to the previous sweep's SINGLE key increments stab_cnt.
    - Any other result sets stab_cnt=1 if SINGLE, else 0.
    - When stab_cnt reaches DEBOUNCE: accept k and go to HELD.
  - HELD:
    - Each NONE sweep increments rel_cnt; any non-NONE sweep clears it.
    - When rel_cnt reaches DEBOUNCE: go to IDLE and clear both counters.
    - No event is emitted while in HELD; a held key reports exactly once.
  - MULTI never produces an event and never counts toward release.
- Acceptance:
  - On the cycle after the deciding sweep's sample, key_valid=1 for one cycle and key_code=k.
  - data and digit_cnt update on that same cycle.
- Buffer update on acceptance:
  - Digit 0-9 with digit_cnt<8: data <= {data[27:0],k}; digit_cnt+1.
  - Digit 0-9 with digit_cnt==8: data unchanged (overflow ignored); key_valid still pulses.
  - A (backspace) with digit_cnt>0: data <= {4'hF,data[31:4]}; digit_cnt-1.
  - A with digit_cnt==0: no change.
  - C (clear): data=32'hFFFF_FFFF, digit_cnt=0.
  - B, D, E, F: reported on key_code/key_valid only; buffer unchanged.
- rst asserted mid-debounce or mid-hold discards all progress. A key still held after reset must re-debounce and is then reported once.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE=3 (sweep = 16 cycles).

1. Hold r1 low while col1 is driven for 6 sweeps, then release -> exactly one key_valid pulse, key_code=5, data=32'hFFFF_FFF5, digit_cnt=1.
2. Then press '3' (r0, c2), then 'A' -> after '3': data=32'hFFFF_FF53; after 'A': data=32'hFFFF_FFF5, digit_cnt=1.
3. Press '7' for 2 sweeps, release for 1 sweep, press for 2 sweeps -> no key_valid; data unchanged.
4. Enter 1..8, then '9' -> after 8 digits: data=32'h1234_5678, digit_cnt=8; '9' pulses key_valid with key_code=9 and data unchanged. Then 'C' -> data=32'hFFFF_FFFF, digit_cnt=0.
5. Press '1' and '2' simultaneously for 10 sweeps -> no event. Then release '2' while still holding '1' -> after 3 sweeps, one event with key_code=1.
6. Hold '4' through an accepted press, pulse rst for 1 cycle, keep holding -> outputs return to reset values; '4' is accepted again 3 sweeps later; data=32'hFFFF_FFF4.

Source files
------------

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad, debounces whole sweeps
// and reports each accepted press once, while maintaining an 8-digit entry
// buffer (high digit first, 4'hF = blank) suitable for the 7-segment scanner.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, exactly one bit low
//   data[31:0] entry buffer, data[31:28] is the leftmost digit
//   key_valid  one-cycle pulse per accepted press
//   key_code   code of the last accepted key
//   digit_cnt  number of entered digits, 0..8
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no key held; counting identical SINGLE sweeps toward accept
// HELD  | key accepted; counting NONE sweeps toward release
module keypad_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] data,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [3:0]  digit_cnt
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_CNT   = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);

  typedef enum logic {IDLE, HELD} state_t;

  state_t        state;
  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [15:0]   hits_acc;
  logic [CW-1:0] stab_cnt, rel_cnt;
  logic [3:0]    prev_idx;

  logic          sample, sweep_end;
  logic [15:0]   col_hits, sweep_hits;
  logic [4:0]    hit_cnt;
  logic [3:0]    hit_idx, hit_code;
  logic          single;
  logic [CW-1:0] stab_next;

  function automatic logic [3:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd0:  code_of = 4'h1;
      4'd1:  code_of = 4'h2;
      4'd2:  code_of = 4'h3;
      4'd3:  code_of = 4'hA;
      4'd4:  code_of = 4'h4;
      4'd5:  code_of = 4'h5;
      4'd6:  code_of = 4'h6;
      4'd7:  code_of = 4'hB;
      4'd8:  code_of = 4'h7;
      4'd9:  code_of = 4'h8;
      4'd10: code_of = 4'h9;
      4'd11: code_of = 4'hC;
      4'd12: code_of = 4'hE;
      4'd13: code_of = 4'h0;
      4'd14: code_of = 4'hF;
      default: code_of = 4'hD;
    endcase
  endfunction

  assign sample    = (div_cnt == DIV_LAST);
  assign sweep_end = sample && (col_idx == 2'd3);

  // Hit bitmap index is {row, column}; the column being sampled now is merged
  // with the columns already captured earlier in the sweep.
  always_comb begin
    col_hits = '0;
    for (int r = 0; r < 4; r++)
      col_hits[{2'(r), col_idx}] = ~row_s2[2'(r)];
    sweep_hits = hits_acc | col_hits;
  end

  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (sweep_hits[4'(i)]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    single   = (hit_cnt == 5'd1);
    hit_code = code_of(hit_idx);
    // A nonzero stab_cnt in IDLE means the previous sweep was SINGLE(prev_idx).
    if (single && (stab_cnt != '0) && (hit_idx == prev_idx))
      stab_next = stab_cnt + 1'b1;
    else
      stab_next = single ? CW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      div_cnt   <= '0;
      col_idx   <= '0;
      col       <= 4'b1110;
      hits_acc  <= '0;
      state     <= IDLE;
      stab_cnt  <= '0;
      rel_cnt   <= '0;
      prev_idx  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      data      <= 32'hFFFF_FFFF;
      digit_cnt <= '0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      key_valid <= 1'b0;

      if (sample) begin
        div_cnt  <= '0;
        col_idx  <= col_idx + 2'd1;
        col      <= ~(4'b0001 << (col_idx + 2'd1));
        hits_acc <= sweep_end ? '0 : sweep_hits;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end

      if (sweep_end) begin
        prev_idx <= hit_idx;
        case (state)
          IDLE: begin
            if (single && (stab_next == DB_CNT)) begin
              state     <= HELD;
              stab_cnt  <= '0;
              rel_cnt   <= '0;
              key_valid <= 1'b1;
              key_code  <= hit_code;
              if (hit_code <= 4'h9) begin
                if (digit_cnt != 4'd8) begin
                  data      <= {data[27:0], hit_code};
                  digit_cnt <= digit_cnt + 4'd1;
                end
              end else if (hit_code == 4'hA) begin
                if (digit_cnt != 4'd0) begin
                  data      <= {4'hF, data[31:4]};
                  digit_cnt <= digit_cnt - 4'd1;
                end
              end else if (hit_code == 4'hC) begin
                data      <= 32'hFFFF_FFFF;
                digit_cnt <= '0;
              end
            end else begin
              stab_cnt <= stab_next;
            end
          end
          HELD: begin
            // MULTI is not NONE, so it clears the release count too.
            if (hit_cnt == 5'd0) begin
              if (rel_cnt == DB_LAST) begin
                state    <= IDLE;
                rel_cnt  <= '0;
                stab_cnt <= '0;
              end else begin
                rel_cnt  <= rel_cnt + 1'b1;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
